// File: rtl/scp_079_ctrl.sv
// Containment controller: tracks the green/yellow/red light phase, times each
// phase, escalates alarms while red persists, and counts rule violations.
module scp_079_ctrl #(
   parameter int unsigned TIMER_W      = 6,
   parameter int unsigned N_ALARM      = 3,
   parameter int unsigned RED_STEP     = 5,
   parameter int unsigned RED_LIMIT    = 20,
   parameter int unsigned CLEAR_CYCLES = 4,
   parameter bit          STRICT       = 1'b1,
   parameter int unsigned CNT_W        = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               green,
   input  logic               yellow,
   input  logic               red,
   output logic [2:0]         state,
   output logic [TIMER_W-1:0] timer,
   output logic [N_ALARM-1:0] alarm,
   output logic               cheat_out,
   output logic [CNT_W-1:0]   cheat_cnt
);

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StGo       = 3'd1,
      StCaution  = 3'd2,
      StHalt     = 3'd3,
      StLockdown = 3'd4
   } state_e;

   localparam logic [TIMER_W-1:0] TimerMax  = {TIMER_W{1'b1}};
   localparam logic [TIMER_W-1:0] RedLast   = TIMER_W'(RED_LIMIT - 1);
   localparam logic [TIMER_W-1:0] ClearLast = TIMER_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CntMax    = {CNT_W{1'b1}};

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 cheat_q, cheat_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic                 green_only, yellow_only, red_only;
   logic                 illegal;
   logic                 cheat_ev;
   logic                 lock_clr;

   assign green_only  = green & ~yellow & ~red;
   assign yellow_only = ~green & yellow & ~red;
   assign red_only    = ~green & ~yellow & red;
   // Two or more lights at once.
   assign illegal     = (green & yellow) | (green & red) | (yellow & red);

   // Next phase, cheat detection and lockdown clear-count reset.
   always_comb begin
      state_d  = state_q;
      cheat_ev = 1'b0;
      lock_clr = 1'b0;
      case (state_q)
         StIdle: begin
            if (green_only)       state_d = StGo;
            else if (yellow_only) state_d = StCaution;
            else if (red_only)    state_d = StHalt;
            cheat_ev = illegal;
         end
         StGo: begin
            if (yellow_only) begin
               state_d = StCaution;
            end else if (red_only) begin
               state_d  = StHalt;
               cheat_ev = STRICT;
            end
            if (illegal) cheat_ev = 1'b1;
         end
         StCaution: begin
            if (green_only)    state_d = StGo;
            else if (red_only) state_d = StHalt;
            cheat_ev = illegal;
         end
         StHalt: begin
            // An exit light wins over the red-limit lockdown.
            if (green_only)             state_d = StGo;
            else if (yellow_only)       state_d = StCaution;
            else if (timer_q == RedLast) state_d = StLockdown;
            cheat_ev = illegal;
         end
         StLockdown: begin
            // Only an unbroken run of green-alone edges releases the lockdown.
            if (!green_only)               lock_clr = 1'b1;
            else if (timer_q == ClearLast) state_d  = StGo;
         end
         default: state_d = StIdle;
      endcase
   end

   // Timer: cleared on any phase change, otherwise saturating count.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q || lock_clr) timer_d = '0;
      else if (timer_q != TimerMax)       timer_d = timer_q + 1'b1;
   end

   // Sticky cheat flag and saturating event counter.
   always_comb begin
      cheat_d = cheat_q;
      cnt_d   = cnt_q;
      if (cheat_ev) begin
         cheat_d = 1'b1;
         if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         timer_q <= '0;
         cheat_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cheat_q <= cheat_d;
         cnt_q   <= cnt_d;
      end
   end

   // Alarm decode straight off the registered phase and timer.
   always_comb begin
      alarm = '0;
      if (state_q == StHalt) begin
         for (int k = 0; k < int'(N_ALARM); k++) begin
            alarm[k] = (32'(timer_q) >= (32'(k) + 32'd1) * RED_STEP);
         end
      end else if (state_q == StLockdown) begin
         alarm = '1;
      end
   end

   assign state     = state_q;
   assign timer     = timer_q;
   assign cheat_out = cheat_q;
   assign cheat_cnt = cnt_q;

endmodule

// File: tb/tb_scp_079_ctrl.sv
// Directed bench for scp_079_ctrl at default parameters.
module tb_scp_079_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       green = 1'b0;
   logic       yellow = 1'b0;
   logic       red = 1'b0;
   logic [2:0] state;
   logic [5:0] timer;
   logic [2:0] alarm;
   logic       cheat_out;
   logic [3:0] cheat_cnt;

   int n_vec = 0;
   int n_err = 0;

   scp_079_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .green     (green),
      .yellow    (yellow),
      .red       (red),
      .state     (state),
      .timer     (timer),
      .alarm     (alarm),
      .cheat_out (cheat_out),
      .cheat_cnt (cheat_cnt)
   );

   always #5 clock = ~clock;

   // Apply lights for one rising edge, then sample 1 time unit later.
   task automatic step(input logic g, input logic y, input logic r);
      green  = g;
      yellow = y;
      red    = r;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      green  = 1'b0;
      yellow = 1'b0;
      red    = 1'b0;
      reset  = 1'b1;
      @(negedge clock);
      reset  = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
      n_vec++; if (timer !== 6'd0) begin n_err++; $display("FAIL rst_timer: got %0d want 0", timer); end
      n_vec++; if (alarm !== 3'b000) begin n_err++; $display("FAIL rst_alarm: got %b want 000", alarm); end
      n_vec++; if (cheat_out !== 1'b0) begin n_err++; $display("FAIL rst_cheat: got %b want 0", cheat_out); end
      n_vec++; if (cheat_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", cheat_cnt); end
      do_reset();
   endtask

   // Green 40 edges, then red straight from GO into HALT and on to LOCKDOWN.
   task automatic test_go_red_lockdown;
      logic [2:0] exp_alarm;
      for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
      n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL go_state: got %0d want 1", state); end
      n_vec++; if (timer !== 6'd39) begin n_err++; $display("FAIL go_timer: got %0d want 39", timer); end
      n_vec++; if (cheat_out !== 1'b0) begin n_err++; $display("FAIL go_cheat: got %b want 0", cheat_out); end
      step(1'b0, 1'b0, 1'b1);
      n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL red_state: got %0d want 3", state); end
      n_vec++; if (timer !== 6'd0) begin n_err++; $display("FAIL red_timer: got %0d want 0", timer); end
      n_vec++; if (cheat_out !== 1'b1) begin n_err++; $display("FAIL red_cheat: got %b want 1", cheat_out); end
      n_vec++; if (cheat_cnt !== 4'd1) begin n_err++; $display("FAIL red_cnt: got %0d want 1", cheat_cnt); end
      for (int t = 1; t <= 19; t++) begin
         step(1'b0, 1'b0, 1'b1);
         exp_alarm = (t >= 15) ? 3'b111 : (t >= 10) ? 3'b011 : (t >= 5) ? 3'b001 : 3'b000;
         n_vec++; if (state !== 3'd3 || timer !== 6'(t)) begin
            n_err++; $display("FAIL halt_t%0d: got state %0d timer %0d want 3/%0d", t, state, timer, t);
         end
         n_vec++; if (alarm !== exp_alarm) begin
            n_err++; $display("FAIL halt_alarm_t%0d: got %b want %b", t, alarm, exp_alarm);
         end
      end
      step(1'b0, 1'b0, 1'b1);
      n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL lock_state: got %0d want 4", state); end
      n_vec++; if (timer !== 6'd0) begin n_err++; $display("FAIL lock_timer: got %0d want 0", timer); end
      n_vec++; if (alarm !== 3'b111) begin n_err++; $display("FAIL lock_alarm: got %b want 111", alarm); end
   endtask

   // Continues from LOCKDOWN: yellow ignored, green 3, idle 1, green 4 -> GO.
   task automatic test_lockdown_clear;
      logic [1:0] exp_t [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic       gseq  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      step(1'b0, 1'b1, 1'b0);
      n_vec++; if (state !== 3'd4 || cheat_cnt !== 4'd1) begin
         n_err++; $display("FAIL lock_yellow: got state %0d cnt %0d want 4/1", state, cheat_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         step(gseq[i], 1'b0, 1'b0);
         n_vec++; if (state !== ((i == 7) ? 3'd1 : 3'd4) || timer !== 6'(exp_t[i])) begin
            n_err++;
            $display("FAIL lock_clr_%0d: got state %0d timer %0d want %0d/%0d", i, state, timer,
                     (i == 7) ? 1 : 4, exp_t[i]);
         end
      end
      n_vec++; if (alarm !== 3'b000) begin n_err++; $display("FAIL clr_alarm: got %b want 000", alarm); end
   endtask

   task automatic test_legal_path;
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      n_vec++; if (state !== 3'd1 || timer !== 6'd2) begin
         n_err++; $display("FAIL path_go: got %0d/%0d want 1/2", state, timer);
      end
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
      n_vec++; if (state !== 3'd2 || timer !== 6'd1) begin
         n_err++; $display("FAIL path_caution: got %0d/%0d want 2/1", state, timer);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
      n_vec++; if (state !== 3'd3 || timer !== 6'd4 || alarm !== 3'b000) begin
         n_err++; $display("FAIL path_halt: got %0d/%0d/%b want 3/4/000", state, timer, alarm);
      end
      n_vec++; if (cheat_out !== 1'b0 || cheat_cnt !== 4'd0) begin
         n_err++; $display("FAIL path_cheat: got %b/%0d want 0/0", cheat_out, cheat_cnt);
      end
   endtask

   task automatic test_back_to_back;
      logic [2:0] exp_s [6] = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2};
      logic [2:0] lts   [6] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b010, 3'b000};
      logic [5:0] exp_t [6] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(lts[i][0], lts[i][1], lts[i][2]);
         n_vec++; if (state !== exp_s[i] || timer !== exp_t[i]) begin
            n_err++; $display("FAIL b2b_%0d: got %0d/%0d want %0d/%0d", i, state, timer, exp_s[i],
                              exp_t[i]);
         end
      end
      n_vec++; if (cheat_cnt !== 4'd0) begin n_err++; $display("FAIL b2b_cnt: got %0d want 0", cheat_cnt); end
   endtask

   task automatic test_cheat_saturate;
      logic [3:0] exp_cnt;
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1'b0, 1'b1);
         exp_cnt = (i > 15) ? 4'd15 : 4'(i);
         n_vec++; if (state !== 3'd1 || cheat_cnt !== exp_cnt) begin
            n_err++; $display("FAIL sat_%0d: got state %0d cnt %0d want 1/%0d", i, state, cheat_cnt, exp_cnt);
         end
      end
      n_vec++; if (cheat_out !== 1'b1 || timer !== 6'd20) begin
         n_err++; $display("FAIL sat_end: got cheat %b timer %0d want 1/20", cheat_out, timer);
      end
   endtask

   task automatic test_exit_priority;
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
      n_vec++; if (state !== 3'd3 || timer !== 6'd19 || alarm !== 3'b111) begin
         n_err++; $display("FAIL prio_pre: got %0d/%0d/%b want 3/19/111", state, timer, alarm);
      end
      step(1'b1, 1'b0, 1'b0);
      n_vec++; if (state !== 3'd1 || timer !== 6'd0 || alarm !== 3'b000) begin
         n_err++; $display("FAIL prio_exit: got %0d/%0d/%b want 1/0/000", state, timer, alarm);
      end
   endtask

   task automatic test_async_reset;
      do_reset();
      step(1'b0, 1'b0, 1'b1);
      n_vec++; if (state !== 3'd3 || cheat_out !== 1'b0) begin
         n_err++; $display("FAIL ar_halt: got %0d/%b want 3/0", state, cheat_out);
      end
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      n_vec++; if (state !== 3'd3 || timer !== 6'd8 || alarm !== 3'b001 || cheat_cnt !== 4'd1) begin
         n_err++; $display("FAIL ar_pre: got %0d/%0d/%b/%0d want 3/8/001/1", state, timer, alarm,
                           cheat_cnt);
      end
      #2;
      reset = 1'b1;
      #1;
      n_vec++; if (state !== 3'd0 || timer !== 6'd0 || alarm !== 3'b000) begin
         n_err++; $display("FAIL ar_mid: got %0d/%0d/%b want 0/0/000", state, timer, alarm);
      end
      n_vec++; if (cheat_out !== 1'b0 || cheat_cnt !== 4'd0) begin
         n_err++; $display("FAIL ar_cheat: got %b/%0d want 0/0", cheat_out, cheat_cnt);
      end
      do_reset();
   endtask

   task automatic test_timer_saturate;
      do_reset();
      for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
      n_vec++; if (state !== 3'd1 || timer !== 6'd63 || alarm !== 3'b000) begin
         n_err++; $display("FAIL tsat: got %0d/%0d/%b want 1/63/000", state, timer, alarm);
      end
   endtask

   initial begin
      test_reset();
      test_go_red_lockdown();
      test_lockdown_clear();
      test_legal_path();
      test_back_to_back();
      test_cheat_saturate();
      test_exit_priority();
      test_async_reset();
      test_timer_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
